uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive buffer placed directly downstream of the UART receiver. It captures each received byte and its parity-error flag on `rx_valid` and queues them in a circular FIFO. The queue is drained through a valid/ready interface to the host/bus side. Status outputs report fill level, almost-full (for RTS flow control) and a sticky overflow flag.

Parameters:
- DEPTH, 16, number of entries; must be a power of 2, minimum 2.
- AFULL_LVL, 12, `almost_full` asserts when count >= AFULL_LVL; legal range 1..DEPTH.
- CNT_W, $clog2(DEPTH)+1, width of the count output (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe: `rx_data` and `parity_error` are valid this cycle.
- parity_error  in  1  parity status of the byte qualified by `rx_valid`.
- rd_ready  in  1  consumer accepts the head entry this cycle.
- rd_valid  out  1  FIFO non-empty; `rd_data` and `rd_perr` hold the head entry.
- rd_data  out  8  head-entry byte; 0 when `rd_valid`=0.
- rd_perr  out  1  head-entry parity-error flag; 0 when `rd_valid`=0.
- count  out  CNT_W  current number of stored entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_LVL; feeds the RTS logic.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full.
- ovf_clr  in  1  one-cycle pulse that clears `overflow`.

Behaviour:
- Reset (async assert, sync release):
  - Read and write pointers are 0, count=0.
  - rd_valid=0, rd_data=0, rd_perr=0, full=0, almost_full=0, overflow=0.
  - Storage contents need no reset.
- Entry format: 9 bits, {perr, data}.
- Pointers:
  - Read and write pointers are log2(DEPTH)+1 bits wide; the MSB is a wrap bit.
  - empty = (pointers equal).
  - full = (index bits equal and wrap bits differ).
- Write (push) = rx_valid && (!full || pop).
  - On push, the entry is stored at the write index and the write pointer increments, wrapping modulo 2*DEPTH.
- Pop = rd_valid && rd_ready.
  - On pop, the read pointer increments.
  - rd_ready while empty has no effect.
- Latency: an entry pushed into an empty FIFO in cycle N appears with rd_valid=1 in cycle N+1. There is no combinational fall-through.
- Output timing:
  - rd_data and rd_perr are a combinational read of the head entry, gated by rd_valid.
  - They stay stable while rd_valid=1 and rd_ready=0.
- Count and flags update each cycle:
  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
  - full, almost_full and rd_valid are registered or derived from pointers and are consistent with count in the same cycle.
- Simultaneous push and pop:
  - When full: push is accepted; count stays DEPTH; no overflow.
  - When empty: only the push takes effect (pop is impossible since rd_valid=0); count goes to 1.
- Overflow:
  - rx_valid && full && !pop drops the byte; stored contents and pointers are unchanged.
  - overflow is set the next cycle.
  - ovf_clr clears it.
  - If a drop and ovf_clr occur in the same cycle, set wins.
- Wrap-around: indices wrap from DEPTH-1 to 0 with no bubble; ordering is strictly FIFO.
- Reset mid-operation: all queued entries are discarded immediately and all outputs return to their reset values.
- Parity configuration does not matter here: `parity_error` is stored as given (0 when the receiver has parity disabled).

Decomposition:
- Shared package `uart_pkg`:
  - typedef struct packed {logic perr; logic [7:0] data;} rx_entry_t.
  - localparam UART_DATA_W = 8.
  - The parity-mode constants shared by uart_tx and uart_rx.
- One sub-module, `uart_fifo_mem`:
  - Parameterised DEPTH × rx_entry_t array.
  - Synchronous write port, asynchronous read port.
  - Pointer, count and flag logic stay in uart_rx_fifo.

Test Plan:
1. Push 0x41 (perr=0), 0x42 (perr=1), 0x43 (perr=0) with rd_ready=0, then hold rd_ready=1 -> rd_valid rises one cycle after the first push. Reads return 41/0, 42/1, 43/0 in order. count goes 3→0; rd_valid=0 after the last pop.
2. Push 16 bytes 0x00..0x0F with DEPTH=16 -> almost_full=1 when count=12, full=1 when count=16. A 17th push of 0xAA sets overflow=1, count stays 16, and the drained data is 0x00..0x0F with no 0xAA.
3. FIFO full, rx_valid=1 (0x55) and rd_ready=1 in the same cycle -> head 0x00 is popped, 0x55 is stored, count stays 16, overflow stays 0.
4. overflow=1, then pulse ovf_clr in the same cycle as another dropped byte -> overflow stays 1. A later ovf_clr with no drop clears it to 0.
5. Run 40 push/pop pairs so the pointers wrap at least twice with a random fill of 0..5 -> the output sequence equals the input sequence and count always matches the scoreboard.
6. Assert reset_n low while count=7 -> all outputs reset immediately (rd_valid=0, count=0, overflow=0). After release, a push of 0x99 is read back as the first entry.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-entry format, data width and parity modes.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  // Parity configuration shared by the transmitter and receiver.
  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_mode_t;

  // One queued receive entry: parity-error flag above the data byte.
  typedef struct packed {
    logic                   perr;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the receive FIFO: synchronous write, asynchronous read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  rx_entry_t       wdata,
  input  logic [AW-1:0]   raddr,
  output rx_entry_t       rdata
);

  rx_entry_t mem [DEPTH];

  // Write the entry on the clock edge; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: queues bytes with their parity flag,
// drains through valid/ready, reports fill level, almost-full and sticky overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_LVL = 12,
  parameter int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_valid,
  input  logic                   parity_error,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd_perr,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   almost_full,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;
  rx_entry_t        wr_entry;
  rx_entry_t        head;

  // Pointer-derived status; the MSB of each pointer is the wrap bit.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count       = CNT_W'(wr_ptr - rd_ptr);
  assign almost_full = (count >= CNT_W'(AFULL_LVL));
  assign rd_valid    = !empty;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign pop  = rd_valid && rd_ready;
  assign push = rx_valid && (!full || pop);
  assign drop = rx_valid && full && !pop;

  assign wr_entry.perr = parity_error;
  assign wr_entry.data = rx_data;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  // Head entry is shown only while the FIFO holds data.
  assign rd_data = rd_valid ? head.data : '0;
  assign rd_perr = rd_valid ? head.perr : 1'b0;

  // Advance write and read pointers on push and pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned AFULL_LVL = 12;
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             parity_error;
  logic             rd_ready;
  logic             rd_valid;
  logic [7:0]       rd_data;
  logic             rd_perr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             almost_full;
  logic             overflow;
  logic             ovf_clr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: a queue of {perr, data} plus the sticky overflow bit.
  logic [8:0] q[$];
  bit         m_ovf = 1'b0;

  uart_rx_fifo #(
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .parity_error (parity_error),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_perr      (rd_perr),
    .count        (count),
    .full         (full),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against what the model says the FIFO holds now.
  task automatic check_outputs(input string tag);
    int unsigned n;
    n = q.size();
    check({tag, ".rd_valid"},    32'(rd_valid),    32'(n != 0));
    check({tag, ".rd_data"},     32'(rd_data),     (n != 0) ? 32'(q[0][7:0]) : 32'd0);
    check({tag, ".rd_perr"},     32'(rd_perr),     (n != 0) ? 32'(q[0][8])   : 32'd0);
    check({tag, ".count"},       32'(count),       n);
    check({tag, ".full"},        32'(full),        32'(n == DEPTH));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AFULL_LVL));
    check({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input string tag, input bit rxv, input logic [7:0] d,
                      input bit pe, input bit rdy, input bit clr);
    bit p;
    bit w;
    int unsigned n;
    rx_valid     = rxv;
    rx_data      = d;
    parity_error = pe;
    rd_ready     = rdy;
    ovf_clr      = clr;
    @(negedge clk);
    check_outputs(tag);
    n = q.size();
    p = (n != 0) && rdy;
    w = rxv && ((n < DEPTH) || p);
    if (p) void'(q.pop_front());
    if (w) q.push_back({pe, d});
    if (rxv && !w) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    rx_valid = 1'b0; rx_data = '0; parity_error = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    check_outputs("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Three bytes, then drain in order.
    step("t1_push0", 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    step("t1_push1", 1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
    step("t1_push2", 1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("t1_drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Fill to full, then one dropped byte.
    for (int i = 0; i < 16; i++) step("t2_fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step("t2_drop", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    idle("t2_after_drop");
    check("t2.overflow_set", 32'(overflow), 32'd1);

    // Clear overflow, then simultaneous push and pop while full.
    step("t2_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step("t3_pushpop", 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    idle("t3_after");
    check("t3.count_full", 32'(count), DEPTH);

    // Drop plus clear in one cycle keeps overflow; a lone clear then clears it.
    step("t4_drop", 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    step("t4_drop_clr", 1'b1, 8'hCC, 1'b1, 1'b0, 1'b1);
    idle("t4_hold");
    check("t4.overflow_kept", 32'(overflow), 32'd1);
    step("t4_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle("t4_cleared");
    check("t4.overflow_clear", 32'(overflow), 32'd0);

    // Drain fully, then random traffic with fill bounded to 0..5.
    for (int i = 0; i < 17; i++) step("t2_drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      bit rxv;
      rxv = ($urandom_range(0, 1) == 1) && (q.size() < 5);
      step("t5_wrap", rxv, 8'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0), 1'b0);
    end

    // Unconstrained random traffic including overflow and clears.
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
    end

    // Build overflow=1 with seven entries queued, then reset mid-cycle.
    for (int i = 0; i < 40; i++) step("t6_fill", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    while (q.size() > 7) step("t6_drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t6.count_pre", 32'(count), 32'd7);
    check("t6.ovf_pre", 32'(overflow), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    check_outputs("t6_async_reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    step("t6_push", 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    step("t6_read", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle("t6_empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
